pipe_cla_adder: RTL
===================

PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning operand/sum width in bits.
REQ-002 The module SHALL have parameter BLK, default 8, meaning carry-lookahead block width and bits resolved per pipeline stage.
REQ-003 The module SHALL have port CLK, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port RSTb, input, 1, reset; RSTb SHALL be asynchronous and active-low.
REQ-005 The module SHALL have port i_vld, input, 1, operand valid.
REQ-006 The module SHALL have port o_rdy, output, 1, operand accept.
REQ-007 The module SHALL have port a, input, WIDTH, addend.
REQ-008 The module SHALL have port b, input, WIDTH, addend.
REQ-009 The module SHALL have port cin, input, 1, carry-in.
REQ-010 The module SHALL have port o_vld, output, 1, result valid.
REQ-011 The module SHALL have port i_rdy, input, 1, downstream accept.
REQ-012 The module SHALL have port o_sum, output, WIDTH, sum.
REQ-013 The module SHALL have port o_c, output, 1, carry-out.

Function
REQ-014 WIDTH SHALL be an integer multiple of BLK, with NSTG = WIDTH/BLK >= 1; otherwise elaboration SHALL fail with a fatal error.
REQ-015 An operand transfer SHALL occur on a cycle with i_vld=1 and o_rdy=1; a result transfer SHALL occur on a cycle with o_vld=1 and i_rdy=1.
REQ-016 Stage k (0..NSTG-1) SHALL add bit slice [k*BLK +: BLK] using the carry registered from stage k-1, or cin for k=0; unprocessed upper slices SHALL be carried skewed, and finished lower slices deskewed, in registers.
REQ-017 Latency SHALL be exactly NSTG cycles from operand transfer to o_vld=1 carrying that result, when not stalled.
REQ-018 Throughput SHALL be one operation per cycle; back-to-back transfers SHALL NOT create bubbles.
REQ-019 {o_c, o_sum} SHALL equal a + b + cin computed at WIDTH+1 bits, with no truncation or wrap error at any WIDTH.
REQ-020 Pipeline advance SHALL be adv = !o_vld | i_rdy; when adv=0 every stage, including its valid bit and data, SHALL hold.
REQ-021 o_rdy SHALL equal adv.
REQ-022 o_sum and o_c SHALL be stable while o_vld=1 and i_rdy=0.
REQ-023 A stage whose valid bit is 0 SHALL carry no result to the output, and its data contents SHALL be irrelevant to every output.
REQ-024 Results SHALL leave the pipeline in operand-transfer order; no result SHALL be dropped or duplicated.

Reset
REQ-025 While RSTb=0, all stage valid bits, o_vld, o_sum and o_c SHALL be 0, immediately and independent of CLK.
REQ-026 Asserting RSTb mid-operation SHALL discard all in-flight operations; after release, no result SHALL appear until NSTG cycles after a new operand transfer.
REQ-027 While RSTb=0, o_rdy SHALL be 1, since it follows o_vld=0.

Configuration
REQ-028 When macro PIPE_ADD_OVF_EN is defined, the module SHALL add output port o_ovf (1 bit), reset value 0, aligned with o_sum; o_ovf SHALL be the two's-complement signed overflow of a+b+cin (a[MSB]==b[MSB] and o_sum[MSB]!=a[MSB]).
REQ-029 Without PIPE_ADD_OVF_EN, port o_ovf and all of its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-030 Package pipe_add_pkg SHALL hold the default WIDTH/BLK constants and a function computing NSTG.
REQ-031 Sub-module cla_blk SHALL implement the combinational BLK-bit carry-lookahead add (generate/propagate, carry-in, sum, carry-out), instantiated once per stage.

Verification (WIDTH=32, BLK=8, NSTG=4 unless stated)
REQ-032 a=FFFFFFFF, b=00000000, cin=1 -> 4 cycles later: o_vld=1, o_sum=00000000, o_c=1.
REQ-033 100 random a/b/cin vectors with i_vld=1 and i_rdy=1 every cycle -> 100 consecutive o_vld cycles starting at cycle 4, each matching the 33-bit reference sum; error count SHALL be 0.
REQ-034 Stall: i_rdy=0 for 3 cycles with 4 operations in flight -> o_rdy=0, o_sum held constant, and all 4 results delivered in order once i_rdy=1.
REQ-035 RSTb pulsed low with 2 operations in flight -> o_vld=0 asynchronously; no stale result appears after release.
REQ-036 PIPE_ADD_OVF_EN defined: a=7FFFFFFF, b=00000001, cin=0 -> o_sum=80000000, o_c=0, o_ovf=1; a=FFFFFFFF, b=00000001 -> o_ovf=0, o_c=1.
REQ-037 Parameter sweep WIDTH=64/BLK=16 and WIDTH=8/BLK=8 -> latency 4 and 1 cycles respectively; a=all-ones, b=0, cin=1 gives o_sum=0, o_c=1.

Source files
------------

// File: rtl/pipe_add_pkg.sv
// pipe_add_pkg -- shared constants and helpers for the pipelined CLA adder.
//   PIPE_ADD_WIDTH : default operand/sum width in bits
//   PIPE_ADD_BLK   : default carry-lookahead block width (bits per stage)
//   pipe_add_nstg  : number of pipeline stages for a given width/block
package pipe_add_pkg;

    localparam int unsigned PIPE_ADD_WIDTH = 32;
    localparam int unsigned PIPE_ADD_BLK   = 8;

    function automatic int unsigned pipe_add_nstg(input int unsigned width,
                                                  input int unsigned blk);
        return (blk == 0) ? 0 : width / blk;
    endfunction

endpackage

// File: rtl/cla_blk.sv
// cla_blk -- combinational W-bit carry-lookahead adder block.
// Ports:
//   a, b : W-bit addends
//   ci   : carry-in
//   s    : W-bit sum
//   co   : carry-out
module cla_blk
    import pipe_add_pkg::*;
#(
    parameter int unsigned W = PIPE_ADD_BLK
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         acc;
    logic         pr;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flat sum-of-products over all lower generate terms
    // and the block carry-in, so no carry ripples through lower bit carries.
    always_comb begin
        c    = '0;
        c[0] = ci;
        acc  = 1'b0;
        pr   = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            acc = g[i];
            pr  = p[i];
            for (int unsigned j = i; j > 0; j--) begin
                acc = acc | (pr & g[j-1]);
                pr  = pr & p[j-1];
            end
            c[i+1] = acc | (pr & ci);
        end
    end

    assign s  = p ^ c[W-1:0];
    assign co = c[W];

endmodule

// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder -- pipelined carry-lookahead adder, BLK bits per stage,
// NSTG = WIDTH/BLK stages, valid/ready handshake on both sides.
// Ports:
//   CLK    : clock, rising edge
//   RSTb   : asynchronous active-low reset
//   i_vld  : operand valid          o_rdy : operand accept (= pipeline advance)
//   a, b   : WIDTH-bit addends      cin   : carry-in
//   o_vld  : result valid           i_rdy : downstream accept
//   o_sum  : WIDTH-bit sum          o_c   : carry-out
//   o_ovf  : signed overflow, present only with `define PIPE_ADD_OVF_EN
module pipe_cla_adder
    import pipe_add_pkg::*;
#(
    parameter int unsigned WIDTH = PIPE_ADD_WIDTH,
    parameter int unsigned BLK   = PIPE_ADD_BLK
) (
    input  logic             CLK,
    input  logic             RSTb,
    input  logic             i_vld,
    output logic             o_rdy,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_c
`ifdef PIPE_ADD_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int unsigned NSTG = pipe_add_nstg(WIDTH, BLK);

    if (BLK == 0 || (WIDTH % BLK) != 0 || NSTG < 1) begin : g_bad_cfg
        $fatal(1, "pipe_cla_adder: WIDTH must be a non-zero multiple of BLK");
    end

    // Whole pipeline moves together; a stall freezes every stage.
    logic adv;
    assign adv   = !o_vld || i_rdy;
    assign o_rdy = adv;

    // Stage k consumes the lowest remaining slice of the skewed operands,
    // appends its sum slice to the deskewed lower sums and forwards the
    // still-unprocessed upper operand bits.
    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int unsigned REM  = WIDTH - k * BLK;
        localparam int unsigned DONE = (k + 1) * BLK;

        logic [REM-1:0]  a_in;
        logic [REM-1:0]  b_in;
        logic            c_in;
        logic            v_in;
        logic [BLK-1:0]  s_blk;
        logic            c_blk;
        logic [DONE-1:0] s_d;
        logic [DONE-1:0] s_q;
        logic            c_q;
        logic            v_q;

        if (k == 0) begin : g_src
            assign a_in = a;
            assign b_in = b;
            assign c_in = cin;
            assign v_in = i_vld;
            assign s_d  = s_blk;
        end else begin : g_src
            assign a_in = g_stg[k-1].g_fwd.a_q;
            assign b_in = g_stg[k-1].g_fwd.b_q;
            assign c_in = g_stg[k-1].c_q;
            assign v_in = g_stg[k-1].v_q;
            assign s_d  = {s_blk, g_stg[k-1].s_q};
        end

        cla_blk #(.W(BLK)) u_cla (
            .a  (a_in[BLK-1:0]),
            .b  (b_in[BLK-1:0]),
            .ci (c_in),
            .s  (s_blk),
            .co (c_blk)
        );

        always_ff @(posedge CLK or negedge RSTb) begin
            if (!RSTb) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                c_q <= c_blk;
                s_q <= s_d;
            end
        end

        // Operand bits only matter alongside a set valid bit, so no reset.
        if (k < NSTG - 1) begin : g_fwd
            logic [REM-BLK-1:0] a_q;
            logic [REM-BLK-1:0] b_q;

            always_ff @(posedge CLK) begin
                if (adv) begin
                    a_q <= a_in[REM-1:BLK];
                    b_q <= b_in[REM-1:BLK];
                end
            end
        end
    end

    assign o_vld = g_stg[NSTG-1].v_q;
    assign o_sum = g_stg[NSTG-1].s_q;
    assign o_c   = g_stg[NSTG-1].c_q;

`ifdef PIPE_ADD_OVF_EN
    // The last stage still sees the operand sign bits, so overflow is
    // resolved there and registered alongside the final sum slice.
    logic ovf_d;
    assign ovf_d = (g_stg[NSTG-1].a_in[BLK-1] == g_stg[NSTG-1].b_in[BLK-1]) &&
                   (g_stg[NSTG-1].s_blk[BLK-1] != g_stg[NSTG-1].a_in[BLK-1]);

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            o_ovf <= 1'b0;
        end else if (adv) begin
            o_ovf <= ovf_d;
        end
    end
`endif

endmodule
